// File: rtl/sqed_wait_mem.sv
// Single-port word memory on the picorv32 native interface with a valid/ready
// handshake, programmable wait states, byte strobes and sticky range errors.
module sqed_wait_mem #(
  parameter int unsigned WORDS       = 256,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          ADDR_CHECK  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [31:0] mem_err_addr
);

  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] err_addr_q;

  logic [31:0] mem_q [WORDS];

  logic        access_c;
  logic [31:0] acc_addr_c;
  logic [31:0] acc_wdata_c;
  logic [3:0]  acc_wstrb_c;
  logic [31:0] off_c;
  logic        oor_c;
  logic [AW-1:0] idx_c;

  // With zero wait states the access happens on the capture edge, straight
  // from the bus; otherwise it uses the request latched in IDLE.
  always_comb begin
    access_c    = 1'b0;
    acc_addr_c  = addr_q;
    acc_wdata_c = wdata_q;
    acc_wstrb_c = wstrb_q;
    if (state_q == S_IDLE) begin
      acc_addr_c  = mem_addr;
      acc_wdata_c = mem_wdata;
      acc_wstrb_c = mem_wstrb;
      access_c    = mem_valid && (WS == 4'd0);
    end else if (state_q == S_WAIT) begin
      access_c = (cnt_q <= 4'd1);
    end
    off_c = (acc_addr_c - ADDR_BASE) >> 2;
    oor_c = ADDR_CHECK && (off_c >= 32'(WORDS));
    idx_c = off_c[AW-1:0];
  end

  // Control FSM with registered handshake, read data and error capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      ready_q <= access_c;
      case (state_q)
        S_IDLE: begin
          if (mem_valid) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            cnt_q   <= WS;
            state_q <= (WS == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
          if (cnt_q <= 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (access_c) begin
        rdata_q <= oor_c ? 32'd0 : mem_q[idx_c];
        if (oor_c) begin
          err_q <= 1'b1;
          if (!err_q) begin
            err_addr_q <= acc_addr_c;
          end
        end
      end
    end
  end

  // Storage is not reset; the read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (access_c && !oor_c) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb_c[i]) begin
          mem_q[idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
        end
      end
    end
  end

  assign mem_ready    = ready_q;
  assign mem_rdata    = rdata_q;
  assign mem_err      = err_q;
  assign mem_err_addr = err_addr_q;

endmodule

// File: doc/sqed_wait_mem.md
# sqed_wait_mem

Parametrised single-port word memory that serves the picorv32 native memory interface with a real valid/ready handshake. It supports programmable wait states, byte-strobed writes, a configurable base address and sticky out-of-range error capture. It replaces the always-ready scratch memory in the SQED processor harness, so that designs under check see non-zero memory latency.

## Interface
- `WORDS`, 256: memory depth in 32-bit words, power of two, 2..65536.
- `ADDR_BASE`, 32'h0000_0000: byte address of word 0; multiple of 4.
- `WAIT_STATES`, 0: extra cycles between request capture and response, 0..15.
- `ADDR_CHECK`, 1: 1 enables out-of-range detection; 0 wraps the address modulo `WORDS`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  request valid from the core; held until `mem_ready`.
- `mem_ready`  out  1  one-cycle response pulse.
- `mem_addr`  in  32  byte address; bits [1:0] are ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; 4'b0000 means a read.
- `mem_rdata`  out  32  read data; valid only while `mem_ready`=1.
- `mem_err`  out  1  sticky flag: an out-of-range access occurred.
- `mem_err_addr`  out  32  byte address of the first out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- **IDLE:**
  - On `mem_valid`=1, latch `mem_addr`, `mem_wdata` and `mem_wstrb`, and load the wait counter with `WAIT_STATES`.
  - If `WAIT_STATES`=0, perform the access on this edge and go to RESP. Otherwise go to WAIT.
- **WAIT:** decrement the counter each cycle. When the counter reaches 1, perform the access on that edge and go to RESP.
- **RESP:** `mem_ready`=1 for exactly one cycle, then IDLE. `mem_valid` is not sampled in RESP.
- **Access, read-first, all from the latched request:**
  - `mem_rdata` is loaded with the old word.
  - Then each byte i with `wstrb[i]`=1 is written from `wdata[8i+7:8i]`.
- **Index:** index = (addr − `ADDR_BASE`) >> 2, computed modulo 2^32.
- **Out of range** means `ADDR_CHECK`=1 and index ≥ `WORDS`:
  - the write is dropped and `mem_rdata` is loaded with 0;
  - `mem_err` is set;
  - `mem_err_addr` is loaded only when `mem_err` was 0 before the access (first error wins).
- If `ADDR_CHECK`=0, index[log2(`WORDS`)−1:0] is used and errors never set.
- `mem_err` and `mem_err_addr` are cleared only by reset.
- If `mem_valid` drops during WAIT (a protocol violation), the captured transaction still completes and `mem_ready` still pulses.
- Memory array contents are not reset and are undefined until written.

## Timing
- **Reset values:** `mem_ready`=0, `mem_rdata`=0, `mem_err`=0, `mem_err_addr`=0, state IDLE, counter 0.
- **Reset assertion mid-transaction:** returns to IDLE immediately. A write whose access edge has already passed stays committed; an uncommitted access is abandoned and no `mem_ready` is issued.
- **Latency:** with `mem_valid` first high in cycle 0 (state IDLE), `mem_ready` is high in cycle `WAIT_STATES`+1.
- **Throughput:** one transfer per `WAIT_STATES`+2 cycles. The earliest next capture is the cycle after RESP.
- `mem_rdata` holds its value after RESP until the next access edge.
- A write followed by a read of the same word returns the new data. There is no same-cycle hazard, since accesses are serialised.

## Test plan
- **Reset:** pulse `resetn` low asynchronously mid-cycle -> all outputs 0 immediately, state IDLE.
- **WAIT_STATES=0, byte-strobed write then read:**
  - write 0xDEADBEEF to 0x10 with `mem_wstrb`=4'hF, then 0x000000AA with `mem_wstrb`=4'h1;
  - read 0x10 -> `mem_rdata`=0xDEADBEAA;
  - `mem_ready` appears exactly 1 cycle after `mem_valid` for each access.
- **WAIT_STATES=3, ADDR_BASE=0x1000:** read 0x1004 -> `mem_ready` in cycle 4 only, for exactly one cycle; `mem_rdata` holds the word at index 1.
- **Out of range, WORDS=32, ADDR_CHECK=1:**
  - write 0x80, then write 0x84 -> both get `mem_ready`, `mem_err`=1, `mem_err_addr`=0x80;
  - read 0x80 -> 0;
  - word 0 is unchanged.
- **ADDR_CHECK=0, WORDS=32:** write 0x12345678 to 0x80 -> reading 0x00 returns 0x12345678; `mem_err` stays 0.
- **Reset mid-WAIT (WAIT_STATES=5):**
  - assert `resetn`=0 in cycle 2 of a write to 0x8 -> no `mem_ready`, word 0x8 unchanged;
  - after release, a fresh read completes normally.
